// File: rtl/fp8_accumulator_if.sv
// fp8_accumulator_if
//   Bundles the sample input stream, the operand/result hookup to the
//   combinational fp_add, and the result output stream of fp8_accumulator.
//   slave  : the accumulator side (consumes samples, produces results)
//   master : the environment side (produces samples, fp_add sum, consumes results)
//   Signals:
//     in_data/in_valid/in_last/in_ready   sample stream
//     add_a/add_b/add_sum                 fp_add operands and sum
//     out_data/out_count/out_nan/out_inf  result payload
//     out_valid/out_ready                 result handshake
interface fp8_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_nan;
  logic                 out_inf;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, in_last, add_sum, out_ready,
    output in_ready, add_a, add_b, out_data, out_count, out_nan, out_inf, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_data, out_count, out_nan, out_inf, out_valid
  );
endinterface

// File: rtl/fp8_accumulator.sv
// fp8_accumulator
//   Streaming accumulation stage for the FP8 (E5M2) datapath. Each accepted
//   sample is summed into a running accumulator through an external
//   combinational fp_add (add_a = accumulator, add_b = sample). When the beat
//   tagged last is accepted, the total, the saturating sample count and the
//   sticky NaN/Inf flags are registered onto the result stream and held until
//   downstream takes them.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, discards any group in progress
//     bus  - fp8_accumulator_if.slave (sample stream, fp_add hookup, result stream)
module fp8_accumulator #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fp8_accumulator_if.slave     bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     POS_ZERO = {WIDTH{1'b0}};

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (&v[MAN_WIDTH +: EXP_WIDTH]) && (|v[MAN_WIDTH-1:0]);
  endfunction

  // Exponent all ones with a zero mantissa.
  function automatic logic is_inf(input logic [WIDTH-1:0] v);
    return (&v[MAN_WIDTH +: EXP_WIDTH]) && !(|v[MAN_WIDTH-1:0]);
  endfunction

  state_t               state_r, state_next_s;
  logic [WIDTH-1:0]     acc_r, acc_next_s;
  logic [CNT_WIDTH-1:0] count_r, count_next_s;
  logic                 nan_r, nan_next_s;
  logic                 inf_r, inf_next_s;
  logic [WIDTH-1:0]     out_data_r, out_data_next_s;
  logic [CNT_WIDTH-1:0] out_count_r, out_count_next_s;
  logic                 out_nan_r, out_nan_next_s;
  logic                 out_inf_r, out_inf_next_s;
  logic                 out_valid_r, out_valid_next_s;

  logic                 in_ready_s;
  logic                 xfer_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic                 nan_acc_s;
  logic                 inf_acc_s;

  assign in_ready_s = (state_r == ACCUM);
  assign xfer_s     = bus.in_valid & in_ready_s;
  // Counter sticks at its maximum rather than wrapping.
  assign cnt_inc_s  = (count_r == CNT_MAX) ? count_r : (count_r + CNT_ONE);
  // Flags including the beat currently being accepted.
  assign nan_acc_s  = nan_r | is_nan(bus.in_data) | is_nan(bus.add_sum);
  assign inf_acc_s  = inf_r | is_inf(bus.add_sum);

  assign bus.in_ready  = in_ready_s;
  assign bus.add_a     = acc_r;
  assign bus.add_b     = bus.in_data;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;
  assign bus.out_nan   = out_nan_r;
  assign bus.out_inf   = out_inf_r;
  assign bus.out_valid = out_valid_r;

  // Next-state and next-register values for the accumulate/present FSM.
  always_comb begin
    state_next_s     = state_r;
    acc_next_s       = acc_r;
    count_next_s     = count_r;
    nan_next_s       = nan_r;
    inf_next_s       = inf_r;
    out_data_next_s  = out_data_r;
    out_count_next_s = out_count_r;
    out_nan_next_s   = out_nan_r;
    out_inf_next_s   = out_inf_r;
    out_valid_next_s = out_valid_r;
    case (state_r)
      ACCUM: begin
        if (xfer_s) begin
          acc_next_s   = bus.add_sum;
          count_next_s = cnt_inc_s;
          nan_next_s   = nan_acc_s;
          inf_next_s   = inf_acc_s;
          if (bus.in_last) begin
            out_data_next_s  = bus.add_sum;
            out_count_next_s = cnt_inc_s;
            out_nan_next_s   = nan_acc_s;
            out_inf_next_s   = inf_acc_s;
            out_valid_next_s = 1'b1;
            state_next_s     = DONE;
          end else begin
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        // Result registers stay untouched until downstream takes them.
        if (bus.out_ready) begin
          out_valid_next_s = 1'b0;
          acc_next_s       = POS_ZERO;
          count_next_s     = CNT_ZERO;
          nan_next_s       = 1'b0;
          inf_next_s       = 1'b0;
          state_next_s     = ACCUM;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ACCUM;
      acc_r       <= POS_ZERO;
      count_r     <= CNT_ZERO;
      nan_r       <= 1'b0;
      inf_r       <= 1'b0;
      out_data_r  <= POS_ZERO;
      out_count_r <= CNT_ZERO;
      out_nan_r   <= 1'b0;
      out_inf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      acc_r       <= acc_next_s;
      count_r     <= count_next_s;
      nan_r       <= nan_next_s;
      inf_r       <= inf_next_s;
      out_data_r  <= out_data_next_s;
      out_count_r <= out_count_next_s;
      out_nan_r   <= out_nan_next_s;
      out_inf_r   <= out_inf_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

endmodule

// File: tb/tb_fp8_accumulator.sv
// tb_fp8_accumulator
//   Directed bench for fp8_accumulator. A behavioural E5M2 adder stands in for
//   fp_add. A second instance with CNT_WIDTH=2 exercises count saturation.
module tb_fp8_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp8_accumulator_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();
  fp8_accumulator_if #(.WIDTH(8), .CNT_WIDTH(2)) bus2 ();

  fp8_accumulator #(.WIDTH(8), .EXP_WIDTH(5), .MAN_WIDTH(2), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fp8_accumulator #(.WIDTH(8), .EXP_WIDTH(5), .MAN_WIDTH(2), .CNT_WIDTH(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Value of an E5M2 finite code as a real.
  function automatic real fp_val(input logic [7:0] v);
    real s;
    int  e;
    e = int'(v[6:2]);
    if (e == 0) begin
      s = real'(v[1:0]);
      e = -16;
    end else begin
      s = 4.0 + real'(v[1:0]);
      e = e - 17;
    end
    for (int i = 0; i < e; i++) s = s * 2.0;
    for (int i = 0; i > e; i--) s = s / 2.0;
    return v[7] ? -s : s;
  endfunction

  // Reference E5M2 adder: nearest representable code, overflow to Inf.
  function automatic logic [7:0] fp_add_model(input logic [7:0] a, input logic [7:0] b);
    logic       a_nan, b_nan, a_inf, b_inf;
    real        r, err, best_err;
    logic [7:0] best, c;
    a_nan = (a[6:2] == 5'h1F) && (a[1:0] != 2'b00);
    b_nan = (b[6:2] == 5'h1F) && (b[1:0] != 2'b00);
    a_inf = (a[6:2] == 5'h1F) && (a[1:0] == 2'b00);
    b_inf = (b[6:2] == 5'h1F) && (b[1:0] == 2'b00);
    if (a_nan || b_nan) return 8'h7F;
    if (a_inf && b_inf) return (a[7] == b[7]) ? a : 8'h7F;
    if (a_inf) return a;
    if (b_inf) return b;
    r = fp_val(a) + fp_val(b);
    if (r >= 61440.0) return 8'h7C;
    if (r <= -61440.0) return 8'hFC;
    best     = 8'h00;
    best_err = (r < 0.0) ? -r : r;
    for (int i = 0; i < 256; i++) begin
      c = i[7:0];
      if (c[6:2] != 5'h1F) begin
        err = fp_val(c) - r;
        if (err < 0.0) err = -err;
        if (err < best_err) begin
          best_err = err;
          best     = c;
        end
      end
    end
    return best;
  endfunction

  always_comb bus.add_sum  = fp_add_model(bus.add_a, bus.add_b);
  always_comb bus2.add_sum = fp_add_model(bus2.add_a, bus2.add_b);

  task automatic beat(input logic [7:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.in_data    = 8'h55;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_last   = 1'b0;
    bus2.in_data   = 8'h00;
    bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", bus.out_count); end
    checks++; if ({bus.out_nan, bus.out_inf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.out_nan, bus.out_inf}); end
    checks++; if (bus.add_a !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", bus.add_a); end
    checks++; if (bus.add_b !== 8'h55) begin errors++; $display("FAIL add_b_passthrough: got %h expected 55", bus.add_b); end
  endtask

  task automatic test_back_to_back();
    beat(8'h3C, 1'b0);
    beat(8'h3C, 1'b0);
    beat(8'h3C, 1'b1);
    idle();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h42) begin errors++; $display("FAIL b2b_data: got %h expected 42", bus.out_data); end
    checks++; if (bus.out_count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus.out_count); end
    checks++; if ({bus.out_nan, bus.out_inf} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b expected 00", {bus.out_nan, bus.out_inf}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_done: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_one_cycle: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_clear();
    beat(8'h40, 1'b1);
    idle();
    checks++; if (bus.out_data !== 8'h40) begin errors++; $display("FAIL clear_data1: got %h expected 40", bus.out_data); end
    checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL clear_count1: got %0d expected 1", bus.out_count); end
    @(posedge clk);
    #1;
    beat(8'h3C, 1'b1);
    idle();
    checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL clear_data2: got %h expected 3c", bus.out_data); end
    checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL clear_count2: got %0d expected 1", bus.out_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    beat(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40;
      bus.in_last  = 1'b1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL bp_data_stable[%0d]: got %h expected 3c", i, bus.out_data); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    idle();
    checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL bp_count_stable: got %0d expected 1", bus.out_count); end
    checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL bp_data_after_pulses: got %h expected 3c", bus.out_data); end
    bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise: got %b expected 1", bus.in_ready); end
    checks++; if (bus.add_a !== 8'h00) begin errors++; $display("FAIL bp_acc_cleared: got %h expected 00", bus.add_a); end
  endtask

  task automatic test_special();
    beat(8'h7B, 1'b0);
    beat(8'h7B, 1'b1);
    idle();
    checks++; if (bus.out_data !== 8'h7C) begin errors++; $display("FAIL inf_data: got %h expected 7c", bus.out_data); end
    checks++; if (bus.out_inf !== 1'b1) begin errors++; $display("FAIL inf_flag: got %b expected 1", bus.out_inf); end
    checks++; if (bus.out_nan !== 1'b0) begin errors++; $display("FAIL inf_nan_flag: got %b expected 0", bus.out_nan); end
    @(posedge clk);
    #1;
    beat(8'h3C, 1'b0);
    beat(8'h7F, 1'b1);
    idle();
    checks++; if (bus.out_nan !== 1'b1) begin errors++; $display("FAIL nan_flag: got %b expected 1", bus.out_nan); end
    checks++; if (bus.out_inf !== 1'b0) begin errors++; $display("FAIL nan_inf_cleared: got %b expected 0", bus.out_inf); end
    checks++; if (bus.out_count !== 8'd2) begin errors++; $display("FAIL nan_count: got %0d expected 2", bus.out_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    bus2.in_data  = 8'h00;
    bus2.in_valid = 1'b1;
    bus2.in_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.in_last = (i == 5) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", bus2.out_valid); end
    checks++; if (bus2.out_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", bus2.out_count); end
    checks++; if (bus2.out_data !== 8'h00) begin errors++; $display("FAIL sat_data: got %h expected 00", bus2.out_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_group();
    beat(8'h3C, 1'b0);
    beat(8'h3C, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.add_a !== 8'h00) begin errors++; $display("FAIL rstmid_acc: got %h expected 00", bus.add_a); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.out_valid); end
    beat(8'h3C, 1'b1);
    idle();
    checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL rstmid_data: got %h expected 3c", bus.out_data); end
    checks++; if (bus.out_count !== 8'd1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", bus.out_count); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_clear();
    test_backpressure();
    test_special();
    test_saturate();
    test_reset_mid_group();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
